// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit; loads return in cycle 3, SW writes in cycle 1, SB/SH read-modify-write.
// Define LSU_BYTE_WE_EN to add o_dmem_be and turn SB/SH into direct byte-enabled writes.
module dmem_lsu #(
  parameter int ADDR_W    = 32,
  parameter bit RST_READY = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [4:0]        i_rd,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  output logic              o_exc,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic              o_dmem_we,
  output logic [31:0]       o_dmem_wdata,
`ifdef LSU_BYTE_WE_EN
  output logic [3:0]        o_dmem_be,
`endif
  input  logic [31:0]       i_dmem_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD      = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_WR      = 2'd3;

  logic [1:0]  state;
  logic        boot;
  logic        req_store;
  logic [2:0]  req_f3;
  logic [1:0]  req_lane;
  logic [4:0]  req_rd;
  logic [31:0] req_wdata;

  logic        f3_ok;
  logic        align_ok;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;
  logic [31:0] st_mask;
  logic [31:0] merged;

  // boot keeps o_ready low for the first post-reset cycle when RST_READY = 0
  assign o_ready = i_rst_n && (state == S_IDLE) && (RST_READY || !boot);

  always_comb begin
    if (i_is_store) begin
      f3_ok = (i_funct3 <= 3'd2);
    end else begin
      f3_ok = (i_funct3 != 3'd3) && (i_funct3 != 3'd6) && (i_funct3 != 3'd7);
    end
    case (i_funct3[1:0])
      2'b01:   align_ok = !i_addr[0];
      2'b10:   align_ok = (i_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  // Load extraction and sub-word merge both work on the word shifted by the latched lane
  always_comb begin
    shamt    = {req_lane, 3'b000};
    rd_shift = i_dmem_rdata >> shamt;
    case (req_f3)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
    st_mask = (req_f3[0] ? 32'h0000_ffff : 32'h0000_00ff) << shamt;
    merged  = (i_dmem_rdata & ~st_mask) | ((req_wdata << shamt) & st_mask);
  end

`ifdef LSU_BYTE_WE_EN
  logic [3:0]  be_next;
  logic [31:0] bw_data;

  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        be_next = 4'b0001 << i_addr[1:0];
        bw_data = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_next = 4'b0011 << i_addr[1:0];
        bw_data = {2{i_wdata[15:0]}};
      end
      default: begin
        be_next = 4'b1111;
        bw_data = i_wdata;
      end
    endcase
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      boot         <= 1'b1;
      req_store    <= 1'b0;
      req_f3       <= 3'd0;
      req_lane     <= 2'd0;
      req_rd       <= 5'd0;
      req_wdata    <= 32'd0;
      o_wb_valid   <= 1'b0;
      o_wb_rd      <= 5'd0;
      o_wb_data    <= 32'd0;
      o_exc        <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_we    <= 1'b0;
      o_dmem_wdata <= 32'd0;
`ifdef LSU_BYTE_WE_EN
      o_dmem_be    <= 4'b0000;
`endif
    end else begin
      boot       <= 1'b0;
      o_wb_valid <= 1'b0;
      o_exc      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            req_store <= i_is_store;
            req_f3    <= i_funct3;
            req_lane  <= i_addr[1:0];
            req_rd    <= i_rd;
            req_wdata <= i_wdata;
            if (!(f3_ok && align_ok)) begin
              o_exc <= 1'b1;
            end else begin
              o_dmem_addr <= {i_addr[ADDR_W-1:2], 2'b00};
              if (!i_is_store) begin
                state <= S_RD;
              end else begin
`ifdef LSU_BYTE_WE_EN
                state        <= S_WR;
                o_dmem_we    <= 1'b1;
                o_dmem_wdata <= bw_data;
                o_dmem_be    <= be_next;
`else
                if (i_funct3 == 3'b010) begin
                  state        <= S_WR;
                  o_dmem_we    <= 1'b1;
                  o_dmem_wdata <= i_wdata;
                end else begin
                  state <= S_RD;
                end
`endif
              end
            end
          end
        end
        S_RD: begin
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (req_store) begin
            state        <= S_WR;
            o_dmem_we    <= 1'b1;
            o_dmem_wdata <= merged;
          end else begin
            state      <= S_IDLE;
            o_wb_valid <= 1'b1;
            o_wb_data  <= ld_ext;
            o_wb_rd    <= req_rd;
          end
        end
        default: begin
          state     <= S_IDLE;
          o_dmem_we <= 1'b0;
`ifdef LSU_BYTE_WE_EN
          o_dmem_be <= 4'b0000;
`endif
        end
      endcase
    end
  end

endmodule
